// File: rtl/graph_pkg.sv
// Shared types and constants for the graph traversal blocks.
// Used by the fetch stage's terminator check and by the neighbour filter.
package graph_pkg;

  localparam int ADDR_W = 32;

  // Null sentinel that terminates each neighbour list.
  localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_POP   = 3'd2;
  localparam logic [2:0] ST_TEST  = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    NF_IDLE  = ST_IDLE,
    NF_CLEAR = ST_CLEAR,
    NF_POP   = ST_POP,
    NF_TEST  = ST_TEST,
    NF_EMIT  = ST_EMIT,
    NF_DONE  = ST_DONE
  } nf_state_t;

endpackage

// File: rtl/neighbor_filter_if.sv
// Neighbour FIFO (show-ahead) and frontier candidate ports of the neighbour filter.
// slave = filter side, master = fetch/frontier side.
interface neighbor_filter_if #(
  parameter int ADDR_W = graph_pkg::ADDR_W
);
  logic [ADDR_W-1:0] neigh_data_in;
  logic              neigh_valid_in;
  logic              neigh_deq_out;
  logic [ADDR_W-1:0] cand_addr_out;
  logic              cand_valid_out;
  logic              cand_ready_in;

  modport slave (
    input  neigh_data_in, neigh_valid_in, cand_ready_in,
    output neigh_deq_out, cand_addr_out, cand_valid_out
  );

  modport master (
    output neigh_data_in, neigh_valid_in, cand_ready_in,
    input  neigh_deq_out, cand_addr_out, cand_valid_out
  );
endinterface

// File: rtl/neighbor_filter_visited_ram.sv
// Direct-mapped visited bitmap: 2^VIS_BITS x 1 single-port synchronous RAM.
// Read-first; a write is visible to a read issued on a later cycle.
module visited_ram #(
  parameter int VIS_BITS = 10
) (
  input  logic                clk_in,
  input  logic [VIS_BITS-1:0] addr,
  input  logic                we,
  input  logic                wdata,
  output logic                rdata
);

  logic mem [2**VIS_BITS];

  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/neighbor_filter.sv
// Drains one neighbour list, drops null terminators and visited vertices,
// marks new ones visited and offers them to the frontier over valid/ready.
module neighbor_filter
  import graph_pkg::*;
#(
  parameter int ADDR_W    = graph_pkg::ADDR_W,
  parameter int VIS_BITS  = 10,
  parameter int MAX_NEIGH = 16,
  localparam int CNT_W    = $clog2(MAX_NEIGH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             clear_in,
  neighbor_filter_if.slave nf,
  output logic             busy_out,
  output logic             done_out,
  output logic [CNT_W-1:0] emit_cnt_out,
  output logic [CNT_W-1:0] drop_cnt_out
);

  nf_state_t           state_q;
  logic [VIS_BITS-1:0] clr_idx_q;
  logic [CNT_W-1:0]    pop_cnt_q;
  logic [CNT_W-1:0]    emit_cnt_q;
  logic [CNT_W-1:0]    drop_cnt_q;
  logic [ADDR_W-1:0]   addr_p1;
  logic [ADDR_W-1:0]   cand_addr_q;
  logic                vld_p2;

  logic [VIS_BITS-1:0] ram_addr;
  logic                ram_we;
  logic                ram_wdata;
  logic                ram_rdata;
  logic                at_limit;

  assign at_limit = (pop_cnt_q == CNT_W'(MAX_NEIGH));

  assign nf.neigh_deq_out  = (state_q == NF_POP) && nf.neigh_valid_in;
  assign nf.cand_addr_out  = cand_addr_q;
  assign nf.cand_valid_out = vld_p2;
  assign busy_out          = (state_q != NF_IDLE);
  assign done_out          = (state_q == NF_DONE);
  assign emit_cnt_out      = emit_cnt_q;
  assign drop_cnt_out      = drop_cnt_q;

  // Single RAM port: clear sweep, TEST mark, otherwise lookup of the FIFO head.
  always_comb begin
    ram_addr  = nf.neigh_data_in[VIS_BITS-1:0];
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    case (state_q)
      NF_CLEAR: begin
        ram_addr = clr_idx_q;
        ram_we   = 1'b1;
      end
      NF_TEST: begin
        ram_addr  = addr_p1[VIS_BITS-1:0];
        ram_we    = ~ram_rdata;
        ram_wdata = 1'b1;
      end
      default: ;
    endcase
  end

  visited_ram #(
    .VIS_BITS(VIS_BITS)
  ) u_visited (
    .clk_in (clk_in),
    .addr   (ram_addr),
    .we     (ram_we),
    .wdata  (ram_wdata),
    .rdata  (ram_rdata)
  );

  // Stage p1: popped address, tested against the bitmap in TEST.
  always_ff @(posedge clk_in) begin
    if (state_q == NF_POP && nf.neigh_valid_in) begin
      addr_p1 <= nf.neigh_data_in;
    end
  end

  // Stage p2: candidate register held until the frontier accepts it.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= NF_CLEAR;
      clr_idx_q   <= '0;
      pop_cnt_q   <= '0;
      emit_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      cand_addr_q <= '0;
      vld_p2      <= 1'b0;
    end else begin
      case (state_q)
        NF_IDLE: begin
          if (clear_in) begin
            clr_idx_q <= '0;
            state_q   <= NF_CLEAR;
          end else if (start_in) begin
            pop_cnt_q  <= '0;
            emit_cnt_q <= '0;
            drop_cnt_q <= '0;
            state_q    <= NF_POP;
          end
        end
        NF_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == '1) begin
            state_q <= NF_DONE;
          end
        end
        NF_POP: begin
          if (nf.neigh_valid_in) begin
            pop_cnt_q <= pop_cnt_q + CNT_W'(1);
            state_q   <= (nf.neigh_data_in == ADDR_W'(NULL_ADDR)) ? NF_DONE : NF_TEST;
          end
        end
        NF_TEST: begin
          if (ram_rdata) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            state_q    <= at_limit ? NF_DONE : NF_POP;
          end else begin
            cand_addr_q <= addr_p1;
            vld_p2      <= 1'b1;
            state_q     <= NF_EMIT;
          end
        end
        NF_EMIT: begin
          if (nf.cand_ready_in) begin
            vld_p2     <= 1'b0;
            emit_cnt_q <= emit_cnt_q + CNT_W'(1);
            state_q    <= at_limit ? NF_DONE : NF_POP;
          end
        end
        NF_DONE: state_q <= NF_IDLE;
        default: state_q <= NF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_filter.sv
// Scoreboard bench for neighbor_filter: a queue-backed show-ahead FIFO feeds the DUT,
// expected candidates are queued at stimulus time and popped by a monitor.
module tb_neighbor_filter;

  localparam int AW = 32;
  localparam int VB = 10;
  localparam int MN = 16;
  localparam int CW = 5;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic          clear_in;
  logic          busy_out;
  logic          done_out;
  logic [CW-1:0] emit_cnt_out;
  logic [CW-1:0] drop_cnt_out;

  neighbor_filter_if #(.ADDR_W(AW)) nif ();

  neighbor_filter #(
    .ADDR_W   (AW),
    .VIS_BITS (VB),
    .MAX_NEIGH(MN)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .clear_in    (clear_in),
    .nf          (nif),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .emit_cnt_out(emit_cnt_out),
    .drop_cnt_out(drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  logic [AW-1:0] fifo_q[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] lst[$];
  logic [AW-1:0] ems[$];
  int n_cmp   = 0;
  int n_bad   = 0;
  int deq_cnt = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // FIFO model: pop on deq at the edge, present the new head just after it.
  always @(posedge clk_in) begin
    if (nif.neigh_deq_out === 1'b1) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      deq_cnt++;
    end
    #1;
    nif.neigh_valid_in = (fifo_q.size() > 0);
    nif.neigh_data_in  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Monitor: candidate handshakes against the scoreboard, plus deq/valid exclusion.
  always @(negedge clk_in) begin
    if (nif.cand_valid_out === 1'b1 || nif.neigh_deq_out === 1'b1)
      check("deq_valid_excl", AW'(nif.cand_valid_out & nif.neigh_deq_out), '0);
    if (rst_in === 1'b1 && nif.cand_valid_out === 1'b1 && nif.cand_ready_in === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cand_unexpected: got %0d, expected no candidate", nif.cand_addr_out);
      end else begin
        check("cand_addr", nif.cand_addr_out, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_done(input string name, input int limit, output int c, output int idle_seen);
    c = -1;
    idle_seen = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk_in);
      #1;
      if (done_out === 1'b1) begin
        c = i;
        return;
      end
      if (busy_out !== 1'b1) idle_seen++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s_timeout: got no done within %0d cycles, expected done", name, limit);
  endtask

  task automatic wait_valid(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (nif.cand_valid_out === 1'b1) return;
      cyc(1);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s_timeout: got no cand_valid within %0d cycles, expected valid", name, limit);
  endtask

  task automatic launch();
    foreach (lst[i]) fifo_q.push_back(lst[i]);
    foreach (ems[i]) exp_q.push_back(ems[i]);
    deq_cnt  = 0;
    start_in = 1'b1;
    cyc(1);
    start_in = 1'b0;
  endtask

  task automatic finish_list(input string name, input int e_emit, input int e_drop, input int e_pop);
    int c, idl;
    wait_done(name, 400, c, idl);
    check({name, "_emit_cnt"}, AW'(emit_cnt_out), AW'(e_emit));
    check({name, "_drop_cnt"}, AW'(drop_cnt_out), AW'(e_drop));
    check({name, "_pops"}, AW'(deq_cnt), AW'(e_pop));
    cyc(1);
  endtask

  task automatic run_list(input string name, input int e_emit, input int e_drop, input int e_pop);
    launch();
    finish_list(name, e_emit, e_drop, e_pop);
  endtask

  initial begin
    int c, idl;
    rst_in            = 1'b0;
    start_in          = 1'b0;
    clear_in          = 1'b0;
    nif.cand_ready_in = 1'b1;
    cyc(3);
    check("rst_busy", AW'(busy_out), 1);
    check("rst_cand_valid", AW'(nif.cand_valid_out), 0);
    check("rst_deq", AW'(nif.neigh_deq_out), 0);
    check("rst_done", AW'(done_out), 0);
    check("rst_emit_cnt", AW'(emit_cnt_out), 0);
    check("rst_drop_cnt", AW'(drop_cnt_out), 0);
    check("rst_cand_addr", nif.cand_addr_out, 0);

    rst_in = 1'b1;
    wait_done("init_clear", 2000, c, idl);
    check("init_clear_cycles", AW'(c), 1024);
    check("init_clear_busy", AW'(idl), 0);
    cyc(1);
    check("idle_done_low", AW'(done_out), 0);
    check("idle_busy_low", AW'(busy_out), 0);

    lst = {32'd5, 32'd9, 32'd0};
    ems = {32'd5, 32'd9};
    run_list("list_5_9", 2, 0, 3);

    lst = {32'd9, 32'd12, 32'd9, 32'd0};
    ems = {32'd12};
    run_list("list_dup", 1, 2, 4);

    // Frontier stalls 10 cycles on address 7.
    nif.cand_ready_in = 1'b0;
    lst = {32'd7, 32'd0};
    ems = {32'd7};
    launch();
    wait_valid("stall", 50);
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", AW'(nif.cand_valid_out), 1);
      check("stall_addr", nif.cand_addr_out, 7);
      check("stall_deq", AW'(nif.neigh_deq_out), 0);
      cyc(1);
    end
    nif.cand_ready_in = 1'b1;
    finish_list("stall", 1, 0, 2);

    // 17 entries, no sentinel: stops after MAX_NEIGH pops.
    lst = {};
    ems = {};
    for (int a = 100; a <= 116; a++) lst.push_back(AW'(a));
    for (int a = 100; a <= 115; a++) ems.push_back(AW'(a));
    launch();
    finish_list("max_neigh", 16, 0, 16);
    check("max_fifo_left", AW'(fifo_q.size()), 1);
    if (fifo_q.size() > 0) check("max_fifo_head", fifo_q[0], 116);
    fifo_q.delete();

    lst = {32'd3, 32'd1027, 32'd0};
    ems = {32'd3};
    run_list("alias", 1, 1, 3);

    clear_in = 1'b1;
    cyc(1);
    clear_in = 1'b0;
    wait_done("clear_cmd", 2000, c, idl);
    check("clear_cmd_cycles", AW'(c), 1024);
    cyc(1);
    lst = {32'd1027, 32'd0};
    ems = {32'd1027};
    run_list("after_clear", 1, 0, 2);

    // Reset while address 40 waits in EMIT.
    nif.cand_ready_in = 1'b0;
    lst = {32'd40, 32'd0};
    ems = {32'd40};
    launch();
    wait_valid("rst_emit", 50);
    check("rst_emit_addr", nif.cand_addr_out, 40);
    rst_in = 1'b0;
    cyc(1);
    check("rst_emit_valid", AW'(nif.cand_valid_out), 0);
    check("rst_emit_busy", AW'(busy_out), 1);
    check("rst_emit_cnt", AW'(emit_cnt_out), 0);
    exp_q.delete();
    fifo_q.delete();
    rst_in            = 1'b1;
    nif.cand_ready_in = 1'b1;
    wait_done("rst_clear", 2000, c, idl);
    check("rst_clear_cycles", AW'(c), 1024);
    cyc(1);
    lst = {32'd40, 32'd0};
    ems = {32'd40};
    run_list("after_rst", 1, 0, 2);

    cyc(2);
    check("sb_empty", AW'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neighbor_filter.md
Name: neighbor_filter

Overview:
- Sits directly downstream of the graph fetch stage and drains its neighbour-address FIFO for one vertex at a time.
- Drops null terminators and already-visited vertices, marks new ones visited, and hands each surviving address to the traversal frontier over a valid/ready port.
- Owns a direct-mapped visited bitmap. The bitmap is cleared per query and auto-cleared after reset.

Parameters:
- ADDR_W, 32, vertex address width.
- VIS_BITS, 10, log2 of visited-table depth; the index is addr[VIS_BITS-1:0].
- MAX_NEIGH, 16, maximum neighbours popped per vertex list.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; one clock, reset synchronous, active-low (0 = reset).
- start_in  input  1  begin draining one neighbour list; accepted only in IDLE.
- clear_in  input  1  clear the visited table; accepted only in IDLE; wins over start_in.
- neigh_data_in  input  ADDR_W  FIFO head (show-ahead).
- neigh_valid_in  input  1  head valid.
- neigh_deq_out  output  1  pop the head this cycle.
- cand_addr_out  output  ADDR_W  unvisited neighbour address.
- cand_valid_out  output  1  candidate valid.
- cand_ready_in  input  1  frontier accepts the candidate.
- busy_out  output  1  not IDLE.
- done_out  output  1  one-cycle pulse at end of a list or a clear.
- emit_cnt_out  output  $clog2(MAX_NEIGH+1)  candidates emitted for the current list.
- drop_cnt_out  output  $clog2(MAX_NEIGH+1)  visited hits dropped for the current list.

Behaviour:
- Reset (rst_in=0 at clk edge):
  - cand_valid_out=0, neigh_deq_out=0, done_out=0, counters=0, cand_addr_out=0.
  - State goes to CLEAR, so busy_out=1.
  - Reset mid-operation abandons the list and the candidate. Table contents are undefined until CLEAR completes.
- FSM states: IDLE, CLEAR, POP, TEST, EMIT, DONE.
- CLEAR:
  - Writes 0 to one entry per cycle, index 0..2^VIS_BITS-1.
  - After the last entry goes to DONE, so a clear takes exactly 2^VIS_BITS cycles plus the DONE cycle.
- IDLE:
  - clear_in=1 -> CLEAR.
  - Otherwise start_in=1 -> POP, with counters zeroed and pop count zeroed.
- POP:
  - Waits while neigh_valid_in=0; neigh_deq_out stays 0 and there is no timeout.
  - When valid: neigh_deq_out=1 for exactly that cycle, neigh_data_in is latched, the visited read is issued (synchronous, 1-cycle latency), and the pop count increments.
  - Latched address == 0 (null sentinel) -> DONE, with no read consequence and no emit.
  - Otherwise -> TEST.
- TEST:
  - Bit=1: drop_cnt+1.
  - Bit=0: write bit=1, load cand_addr_out, assert cand_valid_out, go to EMIT.
  - On a drop, next state is DONE if pop count==MAX_NEIGH, else POP.
- EMIT:
  - cand_valid_out held and cand_addr_out stable until cand_ready_in=1.
  - On the handshake cycle: emit_cnt+1, cand_valid_out=0 next cycle, then DONE if pop count==MAX_NEIGH else POP.
- DONE: done_out=1 for one cycle -> IDLE.
- Throughput: at most one neighbour per 2 cycles (POP+TEST), plus ≥1 EMIT cycle per surviving neighbour.
- Read-after-write: the TEST write commits before the next POP read, so duplicates within a list are dropped.
- Aliasing: addresses equal in the low VIS_BITS bits share a bit. A later one is dropped (false positive, accepted). No false negatives.
- MAX_NEIGH reached without a sentinel: stop popping. Remaining FIFO entries are left untouched.
- Counters hold their values after DONE until the next accepted start_in. They saturate-free, since the bound is MAX_NEIGH.
- start_in and clear_in outside IDLE are ignored (no queuing).
- Only one of cand_valid_out and neigh_deq_out is ever high in a given cycle.

Decomposition:
- graph_pkg holds:
  - the nf_state_t enum;
  - ADDR_W;
  - NULL_ADDR = 0, shared with the fetch stage's terminator check.
- One sub-module, visited_ram: 2^VIS_BITS x 1 single-port synchronous RAM with write-enable, for BRAM/LUTRAM inference.

Test Plan:
- Reset release -> busy_out=1 for 1024 cycles, then a done_out pulse. Then FIFO [5,9,0] + start -> emits 5 then 9, done, emit_cnt=2, drop_cnt=0, 3 pops.
- Same query, FIFO [9,12,9,0] -> emits only 12; drop_cnt=2 (one prior visit, one in-list duplicate).
- FIFO [7,0], cand_ready_in low for 10 cycles -> cand_valid_out=1 and cand_addr_out=7 stable throughout, neigh_deq_out=0 throughout; accepted on the 11th cycle.
- FIFO holds 17 nonzero addresses 100..116, no sentinel -> exactly 16 pops, emits 100..115, done; 116 remains in FIFO.
- Aliasing: FIFO [3,1027,0] with VIS_BITS=10 -> emits 3, drops 1027. Then clear_in, then [1027,0] -> emits 1027.
- rst_in=0 during EMIT of address 40 -> cand_valid_out=0 the next cycle, CLEAR restarts; after clear, [40,0] emits 40.
